// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone pipelined round-robin arbiter with outstanding-transaction throttling.
// Optional watchdog (and timeout_o port) enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int ADR_W           = 28,
    parameter int DAT_W           = 32,
    parameter int MAX_OUTSTANDING = 4
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
`ifdef WB_ARB_TIMEOUT_EN
    output logic               timeout_o,
`endif
    input  logic               wbs0_cyc,
    input  logic               wbs0_stb,
    input  logic [ADR_W-1:0]   wbs0_adr,
    input  logic [DAT_W-1:0]   wbs0_dat_m,
    input  logic [DAT_W/8-1:0] wbs0_sel,
    input  logic               wbs0_we,
    output logic [DAT_W-1:0]   wbs0_dat_s,
    output logic               wbs0_ack,
    output logic               wbs0_err,
    output logic               wbs0_stall,
    input  logic               wbs1_cyc,
    input  logic               wbs1_stb,
    input  logic [ADR_W-1:0]   wbs1_adr,
    input  logic [DAT_W-1:0]   wbs1_dat_m,
    input  logic [DAT_W/8-1:0] wbs1_sel,
    input  logic               wbs1_we,
    output logic [DAT_W-1:0]   wbs1_dat_s,
    output logic               wbs1_ack,
    output logic               wbs1_err,
    output logic               wbs1_stall,
    output logic               wbm_cyc,
    output logic               wbm_stb,
    output logic [ADR_W-1:0]   wbm_adr,
    output logic [DAT_W-1:0]   wbm_dat_m,
    output logic [DAT_W/8-1:0] wbm_sel,
    output logic               wbm_we,
    input  logic [DAT_W-1:0]   wbm_dat_s,
    input  logic               wbm_ack,
    input  logic               wbm_err,
    input  logic               wbm_stall
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               rr_ptr, rr_ptr_nxt;
    logic               end_cycle;
    logic [CNT_W-1:0]   outstanding, outstanding_nxt;
    logic               full;
    logic               issue;
    logic               done;
    logic               dec;
    logic               timeout;

    assign full  = (outstanding == CNT_W'(MAX_OUTSTANDING));
    assign issue = wbm_stb & ~wbm_stall;
    assign done  = wbm_ack | wbm_err;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wdog;

    assign timeout   = (state != IDLE) && (outstanding != '0) &&
                       (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout;

    // The watchdog only runs while the owner waits on an unanswered transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (end_cycle || timeout || done || (outstanding == '0)) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        end_cycle  = 1'b0;
        case (state)
            IDLE: begin
                if (wbs0_cyc && !wbs1_cyc) begin
                    state_nxt = GRANT0;
                end else if (wbs1_cyc && !wbs0_cyc) begin
                    state_nxt = GRANT1;
                end else if (wbs0_cyc && wbs1_cyc) begin
                    state_nxt = rr_ptr ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                if (!wbs0_cyc) begin
                    end_cycle  = 1'b1;
                    rr_ptr_nxt = 1'b1;
                    state_nxt  = wbs1_cyc ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!wbs1_cyc) begin
                    end_cycle  = 1'b1;
                    rr_ptr_nxt = 1'b0;
                    state_nxt  = wbs0_cyc ? GRANT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A timeout retires one transaction in place of any ack seen that cycle.
    always_comb begin
        dec             = timeout | (done & (outstanding != '0));
        outstanding_nxt = outstanding;
        if (end_cycle) begin
            outstanding_nxt = '0;
        end else begin
            case ({issue, dec})
                2'b10:   outstanding_nxt = outstanding + 1'b1;
                2'b01:   outstanding_nxt = outstanding - 1'b1;
                default: outstanding_nxt = outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    always_comb begin
        wbm_cyc    = 1'b0;
        wbm_stb    = 1'b0;
        wbm_adr    = '0;
        wbm_dat_m  = '0;
        wbm_sel    = '0;
        wbm_we     = 1'b0;
        wbs0_dat_s = '0;
        wbs0_ack   = 1'b0;
        wbs0_err   = 1'b0;
        wbs0_stall = 1'b1;
        wbs1_dat_s = '0;
        wbs1_ack   = 1'b0;
        wbs1_err   = 1'b0;
        wbs1_stall = 1'b1;
        case (state)
            GRANT0: begin
                wbm_cyc    = wbs0_cyc;
                wbm_stb    = wbs0_stb & ~full;
                wbm_adr    = wbs0_adr;
                wbm_dat_m  = wbs0_dat_m;
                wbm_sel    = wbs0_sel;
                wbm_we     = wbs0_we;
                wbs0_stall = wbm_stall | full;
                wbs0_ack   = wbm_ack & ~timeout;
                wbs0_err   = wbm_err | timeout;
                wbs0_dat_s = wbm_dat_s;
            end
            GRANT1: begin
                wbm_cyc    = wbs1_cyc;
                wbm_stb    = wbs1_stb & ~full;
                wbm_adr    = wbs1_adr;
                wbm_dat_m  = wbs1_dat_m;
                wbm_sel    = wbs1_sel;
                wbm_we     = wbs1_we;
                wbs1_stall = wbm_stall | full;
                wbs1_ack   = wbm_ack & ~timeout;
                wbs1_err   = wbm_err | timeout;
                wbs1_dat_s = wbm_dat_s;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter; the watchdog section runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;

    localparam int ADR_W = 28;
    localparam int DAT_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               wbs0_cyc, wbs0_stb, wbs0_we;
    logic [ADR_W-1:0]   wbs0_adr;
    logic [DAT_W-1:0]   wbs0_dat_m;
    logic [DAT_W/8-1:0] wbs0_sel;
    logic [DAT_W-1:0]   wbs0_dat_s;
    logic               wbs0_ack, wbs0_err, wbs0_stall;
    logic               wbs1_cyc, wbs1_stb, wbs1_we;
    logic [ADR_W-1:0]   wbs1_adr;
    logic [DAT_W-1:0]   wbs1_dat_m;
    logic [DAT_W/8-1:0] wbs1_sel;
    logic [DAT_W-1:0]   wbs1_dat_s;
    logic               wbs1_ack, wbs1_err, wbs1_stall;
    logic               wbm_cyc, wbm_stb, wbm_we;
    logic [ADR_W-1:0]   wbm_adr;
    logic [DAT_W-1:0]   wbm_dat_m;
    logic [DAT_W/8-1:0] wbm_sel;
    logic [DAT_W-1:0]   wbm_dat_s;
    logic               wbm_ack, wbm_err, wbm_stall;
`ifdef WB_ARB_TIMEOUT_EN
    logic               timeout_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int issued;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .ADR_W(ADR_W),
        .DAT_W(DAT_W),
        .MAX_OUTSTANDING(4)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef WB_ARB_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .wbs0_cyc(wbs0_cyc), .wbs0_stb(wbs0_stb), .wbs0_adr(wbs0_adr),
        .wbs0_dat_m(wbs0_dat_m), .wbs0_sel(wbs0_sel), .wbs0_we(wbs0_we),
        .wbs0_dat_s(wbs0_dat_s), .wbs0_ack(wbs0_ack), .wbs0_err(wbs0_err),
        .wbs0_stall(wbs0_stall),
        .wbs1_cyc(wbs1_cyc), .wbs1_stb(wbs1_stb), .wbs1_adr(wbs1_adr),
        .wbs1_dat_m(wbs1_dat_m), .wbs1_sel(wbs1_sel), .wbs1_we(wbs1_we),
        .wbs1_dat_s(wbs1_dat_s), .wbs1_ack(wbs1_ack), .wbs1_err(wbs1_err),
        .wbs1_stall(wbs1_stall),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_adr(wbm_adr),
        .wbm_dat_m(wbm_dat_m), .wbm_sel(wbm_sel), .wbm_we(wbm_we),
        .wbm_dat_s(wbm_dat_s), .wbm_ack(wbm_ack), .wbm_err(wbm_err),
        .wbm_stall(wbm_stall)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, landing 1ns after the edge, then let new inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic m0(input logic cyc, input logic stb, input logic [ADR_W-1:0] adr);
        wbs0_cyc = cyc; wbs0_stb = stb; wbs0_adr = adr;
    endtask

    task automatic m1(input logic cyc, input logic stb, input logic [ADR_W-1:0] adr);
        wbs1_cyc = cyc; wbs1_stb = stb; wbs1_adr = adr;
    endtask

    task automatic slv(input logic stall, input logic ack, input logic err, input logic [DAT_W-1:0] dat);
        wbm_stall = stall; wbm_ack = ack; wbm_err = err; wbm_dat_s = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0(1'b0, 1'b0, '0);
        m1(1'b0, 1'b0, '0);
        slv(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        wbs0_we = 1'b0; wbs0_dat_m = 32'h1111_0000; wbs0_sel = 4'hF;
        wbs1_we = 1'b1; wbs1_dat_m = 32'h2222_0000; wbs1_sel = 4'h3;
        do_reset();

        $display("[TB] reset state");
        check("rst_state", dut.state, 0);
        check("rst_rr_ptr", dut.rr_ptr, 0);
        check("rst_outstanding", dut.outstanding, 0);
        check("rst_wbm_cyc", wbm_cyc, 0);
        check("rst_wbm_stb", wbm_stb, 0);
        check("rst_stalls", {wbs0_stall, wbs1_stall}, 2'b11);
        check("rst_acks_errs", {wbs0_ack, wbs0_err, wbs1_ack, wbs1_err}, 0);
        check("rst_dat_s", {wbs0_dat_s, wbs1_dat_s}, 0);

        $display("[TB] single master pipelined reads");
        m0(1'b1, 1'b1, 28'h100);
        settle();
        check("sm_first_stb_stalled", wbs0_stall, 1);
        check("sm_idle_wbm_cyc", wbm_cyc, 0);
        tick();
        check("sm_grant0", dut.state, 1);
        check("sm_wbm_cyc", wbm_cyc, 1);
        check("sm_wbm_stb", wbm_stb, 1);
        check("sm_wbm_adr", wbm_adr, 28'h100);
        check("sm_wbm_sel_we", {wbm_sel, wbm_we}, {4'hF, 1'b0});
        check("sm_wbs0_stall", wbs0_stall, 0);
        check("sm_wbs1_stall", wbs1_stall, 1);
        tick();
        m0(1'b1, 1'b1, 28'h101);
        slv(1'b0, 1'b1, 1'b0, 32'hA0);
        settle();
        check("sm_out_1", dut.outstanding, 1);
        check("sm_ack0_a", wbs0_ack, 1);
        check("sm_dat0_a", wbs0_dat_s, 32'hA0);
        check("sm_wbs1_quiet", {wbs1_ack, wbs1_dat_s}, 0);
        tick();
        m0(1'b1, 1'b1, 28'h102);
        slv(1'b0, 1'b1, 1'b0, 32'hA1);
        settle();
        check("sm_out_accept_ack", dut.outstanding, 1);
        check("sm_wbm_adr_2", wbm_adr, 28'h102);
        check("sm_ack0_b", {wbs0_ack, wbs0_dat_s}, {1'b1, 32'hA1});
        tick();
        m0(1'b1, 1'b0, 28'h102);
        slv(1'b0, 1'b1, 1'b0, 32'hA2);
        settle();
        check("sm_ack0_c", {wbs0_ack, wbs0_dat_s}, {1'b1, 32'hA2});
        check("sm_wbs1_ack_off", wbs1_ack, 0);
        tick();
        slv(1'b0, 1'b0, 1'b0, '0);
        m0(1'b0, 1'b0, '0);
        settle();
        check("sm_out_drained", dut.outstanding, 0);
        check("sm_cyc_drop_comb", wbm_cyc, 0);
        tick();
        check("sm_back_idle", dut.state, 0);
        check("sm_rr_ptr_1", dut.rr_ptr, 1);

        $display("[TB] contention");
        do_reset();
        m0(1'b1, 1'b0, '0);
        m1(1'b1, 1'b0, 28'h200);
        tick();
        check("ct_grant0_first", dut.state, 1);
        check("ct_stalls", {wbs0_stall, wbs1_stall}, 2'b01);
        tick();
        m0(1'b0, 1'b0, '0);
        settle();
        check("ct_wbm_cyc_drop", wbm_cyc, 0);
        tick();
        check("ct_grant1_no_gap", dut.state, 2);
        check("ct_rr_ptr_1", dut.rr_ptr, 1);
        check("ct_wbm_cyc_m1", wbm_cyc, 1);
        check("ct_wbm_we_m1", {wbm_we, wbm_sel}, {1'b1, 4'h3});
        check("ct_stalls_m1", {wbs0_stall, wbs1_stall}, 2'b10);
        m1(1'b0, 1'b0, '0);
        tick();
        check("ct_idle", dut.state, 0);
        check("ct_rr_ptr_0", dut.rr_ptr, 0);

        $display("[TB] throttle");
        do_reset();
        m0(1'b1, 1'b1, 28'h300);
        tick();
        issued = 0;
        for (int i = 0; i < 6; i++) begin
            check("th_outstanding", dut.outstanding, (i < 4) ? i : 4);
            check("th_wbm_stb", wbm_stb, (i < 4) ? 1 : 0);
            check("th_wbs0_stall", wbs0_stall, (i < 4) ? 0 : 1);
            if (wbm_stb && !wbm_stall) issued++;
            tick();
        end
        check("th_issued", issued, 4);
        slv(1'b0, 1'b1, 1'b0, 32'hB0);
        settle();
        check("th_full_ack", {wbs0_ack, wbs0_stall, wbm_stb}, 3'b110);
        tick();
        settle();
        check("th_out_3", dut.outstanding, 3);
        check("th_accept_with_ack", {wbm_stb, wbs0_stall}, 2'b10);
        tick();
        slv(1'b0, 1'b0, 1'b0, '0);
        settle();
        check("th_out_hold_3", dut.outstanding, 3);
        tick();
        m0(1'b1, 1'b0, 28'h300);
        slv(1'b0, 1'b1, 1'b0, 32'hB1);
        settle();
        check("th_out_4_again", dut.outstanding, 4);
        for (int i = 0; i < 4; i++) tick();
        slv(1'b0, 1'b0, 1'b0, '0);
        settle();
        check("th_drained", dut.outstanding, 0);
        m0(1'b0, 1'b0, '0);
        tick();
        check("th_idle", dut.state, 0);

        $display("[TB] abort with late acks");
        do_reset();
        m1(1'b1, 1'b1, 28'h400);
        tick();
        check("ab_grant1", dut.state, 2);
        tick();
        tick();
        m1(1'b1, 1'b0, 28'h400);
        settle();
        check("ab_out_2", dut.outstanding, 2);
        m1(1'b0, 1'b0, '0);
        settle();
        check("ab_wbm_cyc_drop", wbm_cyc, 0);
        tick();
        slv(1'b0, 1'b1, 1'b0, 32'hC0);
        settle();
        check("ab_idle", dut.state, 0);
        check("ab_out_0", dut.outstanding, 0);
        check("ab_late_ack_1", {wbs0_ack, wbs1_ack, wbs1_dat_s}, 0);
        tick();
        settle();
        check("ab_late_ack_2", {wbs0_ack, wbs1_ack}, 0);
        check("ab_out_sat", dut.outstanding, 0);
        slv(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] reset mid-burst");
        do_reset();
        m0(1'b1, 1'b1, 28'h500);
        tick();
        tick();
        tick();
        tick();
        check("rm_out_3", dut.outstanding, 3);
        m0(1'b1, 1'b0, 28'h500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rm_state_idle", dut.state, 0);
        check("rm_out_0", dut.outstanding, 0);
        check("rm_wbm_cyc", wbm_cyc, 0);
        check("rm_stalls", {wbs0_stall, wbs1_stall}, 2'b11);
        m0(1'b0, 1'b0, '0);
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        do_reset();
        m0(1'b1, 1'b1, 28'h600);
        tick();
        check("to_issue", wbm_stb, 1);
        tick();
        m0(1'b1, 1'b0, 28'h600);
        settle();
        for (int j = 1; j <= 16; j++) begin
            check("to_timeout_o", timeout_o, (j == 16) ? 1 : 0);
            check("to_wbs0_err", wbs0_err, (j == 16) ? 1 : 0);
            tick();
        end
        check("to_out_0", dut.outstanding, 0);
        check("to_pulse_end", {timeout_o, wbs0_err}, 0);
        m0(1'b0, 1'b0, '0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
